// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: controller for the F1 start-light shift register.
// Generates light_en / light_clr strobes from a prescaled tick, holds all
// lights for a pseudo-random interval, signals lights-out, then measures
// the driver's reaction time and flags jump starts.
// Optional build macro: F1_TIMEOUT_EN -- when defined, a reaction counter
// that saturates in TIMING ends the measurement with react_time=16'hFFFF.
module f1_start_sequencer #(
  parameter int unsigned N_LIGHTS       = 8,
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned STEP_TICKS     = 100,
  parameter int unsigned MIN_HOLD_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        react,
  output logic        light_en,
  output logic        light_clr,
  output logic        go,
  output logic        busy,
  output logic [15:0] react_time,
  output logic        react_valid,
  output logic        jump_start
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W  = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned LIT_W   = $clog2(N_LIGHTS + 1);
  localparam int unsigned HOLD_W  = $clog2(MIN_HOLD_TICKS + 128);
  localparam int unsigned RT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LIGHTING,
    S_HOLD,
    S_OUT,
    S_TIMING
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PRESC_W-1:0]  presc;
  logic [6:0]          lfsr;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_nxt;
  logic [LIT_W-1:0]    lit_cnt;
  logic [LIT_W-1:0]    lit_nxt;
  logic [LIT_W-1:0]    lit_inc_c;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [RT_W-1:0]     react_cnt;
  logic [RT_W-1:0]     react_cnt_nxt;
  logic [RT_W-1:0]     react_time_nxt;
  logic                light_en_nxt;
  logic                light_clr_nxt;
  logic                go_nxt;
  logic                react_valid_nxt;
  logic                jump_start_nxt;
  logic                tick_c;
  logic                jump_c;

  assign tick_c = (presc == PRESC_W'(TICK_DIV - 1));
  assign jump_c = react && ((state == S_CLEAR) || (state == S_LIGHTING) || (state == S_HOLD));

  // Prescaler: free-running tick divider, restarted when a sequence begins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if ((state == S_IDLE) && (state_nxt != S_IDLE)) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // LFSR x^7+x^6+1, advances every cycle; seed is non-zero so it never locks up.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= 7'h01;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      lit_cnt     <= '0;
      hold_cnt    <= '0;
      react_cnt   <= '0;
      react_time  <= '0;
      light_en    <= 1'b0;
      light_clr   <= 1'b0;
      go          <= 1'b0;
      busy        <= 1'b0;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
    end else begin
      state       <= state_nxt;
      step_cnt    <= step_nxt;
      lit_cnt     <= lit_nxt;
      hold_cnt    <= hold_nxt;
      react_cnt   <= react_cnt_nxt;
      react_time  <= react_time_nxt;
      light_en    <= light_en_nxt;
      light_clr   <= light_clr_nxt;
      go          <= go_nxt;
      busy        <= (state_nxt != S_IDLE);
      react_valid <= react_valid_nxt;
      jump_start  <= jump_start_nxt;
    end
  end

  // Next-state and next-output decode; strobes are registered so they appear
  // in the cycle after the decision (light_clr/go line up with CLEAR/OUT).
  always_comb begin
    state_nxt       = state;
    step_nxt        = step_cnt;
    lit_nxt         = lit_cnt;
    hold_nxt        = hold_cnt;
    react_cnt_nxt   = react_cnt;
    react_time_nxt  = react_time;
    light_en_nxt    = 1'b0;
    light_clr_nxt   = 1'b0;
    go_nxt          = 1'b0;
    react_valid_nxt = 1'b0;
    jump_start_nxt  = 1'b0;
    lit_inc_c       = lit_cnt + LIT_W'(1);

    if (jump_c) begin
      // Early react aborts the sequence and beats any same-cycle light/expiry.
      state_nxt      = S_IDLE;
      jump_start_nxt = 1'b1;
      light_clr_nxt  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state_nxt     = S_CLEAR;
            light_clr_nxt = 1'b1;
          end
        end

        S_CLEAR: begin
          step_nxt  = '0;
          lit_nxt   = '0;
          state_nxt = S_LIGHTING;
        end

        S_LIGHTING: begin
          if (tick_c) begin
            if (step_cnt == STEP_W'(STEP_TICKS - 1)) begin
              step_nxt     = '0;
              lit_nxt      = lit_inc_c;
              light_en_nxt = 1'b1;
              if (lit_inc_c == LIT_W'(N_LIGHTS)) begin
                state_nxt = S_HOLD;
                hold_nxt  = HOLD_W'(MIN_HOLD_TICKS) + HOLD_W'(lfsr);
              end
            end else begin
              step_nxt = step_cnt + STEP_W'(1);
            end
          end
        end

        S_HOLD: begin
          if (tick_c) begin
            if (hold_cnt == '0) begin
              state_nxt     = S_OUT;
              go_nxt        = 1'b1;
              light_clr_nxt = 1'b1;
              react_cnt_nxt = '0;
            end else begin
              hold_nxt = hold_cnt - HOLD_W'(1);
            end
          end
        end

        S_OUT: begin
          react_cnt_nxt = '0;
          if (react) begin
            state_nxt       = S_IDLE;
            react_time_nxt  = '0;
            react_valid_nxt = 1'b1;
          end else begin
            state_nxt = S_TIMING;
          end
        end

        S_TIMING: begin
          if (react) begin
            state_nxt       = S_IDLE;
            react_time_nxt  = react_cnt;
            react_valid_nxt = 1'b1;
          end else begin
            if (tick_c && (react_cnt != 16'hFFFF)) begin
              react_cnt_nxt = react_cnt + RT_W'(1);
            end
`ifdef F1_TIMEOUT_EN
            if (react_cnt == 16'hFFFF) begin
              state_nxt       = S_IDLE;
              react_time_nxt  = 16'hFFFF;
              react_valid_nxt = 1'b1;
            end
`endif
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule
